// File: rtl/tx_dma_pkg.sv
// Shared types and widths for the TX DMA stream path: wide beat struct and fill-level sizing.
package tx_dma_pkg;

  localparam int TX_BYTE_W     = 8;
  localparam int TX_BEAT_BYTES = 64;

  function automatic int fill_w(input int out_bytes);
    return $clog2(out_bytes) + 1;
  endfunction

  localparam int TX_FILL_W = fill_w(TX_BEAT_BYTES);

  typedef struct packed {
    logic [63:0][7:0] a64x8_tdata;
    logic [63:0]      v64_tkeep;
    logic             tlast;
  } ts_tx_dma_axis;

endpackage

// File: rtl/tx_keep_count.sv
// Combinational tkeep analysis: byte count and whether the enables are contiguous from bit 0.
module tx_keep_count #(
  parameter int W = 8
) (
  input  logic [W-1:0]       keep,
  output logic [$clog2(W):0] n,
  output logic               contig
);

  localparam int N_W = $clog2(W) + 1;

  logic [W-1:0] low_mask;

  always_comb begin
    n = '0;
    for (int i = 0; i < W; i++) begin
      n = n + N_W'(keep[i]);
    end
  end

  always_comb begin
    low_mask = '0;
    for (int i = 0; i < W; i++) begin
      low_mask[i] = (i < int'(n));
    end
    contig = (keep == low_mask);
  end

endmodule

// File: rtl/tx_dma_axis_packer.sv
// Packs narrow AXIS words into wide beats; beat appears one cycle after the completing accept.
// Input ready is combinational from the output stage, so a stalled beat stops intake at once.
module tx_dma_axis_packer
  import tx_dma_pkg::*;
#(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 64,
  parameter int CNT_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [IN_BYTES*8-1:0]  i_s_tdata,
  input  logic [IN_BYTES-1:0]    i_s_tkeep,
  input  logic                   i_s_tlast,
  input  logic                   i_s_tvalid,
  output logic                   o_s_tready,
  output logic [OUT_BYTES*8-1:0] o_m_tdata,
  output logic [OUT_BYTES-1:0]   o_m_tkeep,
  output logic                   o_m_tlast,
  output logic                   o_m_tvalid,
  input  logic                   i_m_tready,
  output logic [CNT_W-1:0]       o_pkt_cnt,
  output logic                   o_err
);

  localparam int FILL_W = fill_w(OUT_BYTES);
  localparam int N_W    = $clog2(IN_BYTES) + 1;
  localparam int DAT_W  = OUT_BYTES * TX_BYTE_W;

  typedef enum logic {IDLE_FILL, HOLD} state_t;

  state_t                state_q, state_d;
  ts_tx_dma_axis         beat_q, beat_d;
  logic [DAT_W-1:0]      acc_dat_q, merged_dat;
  logic [OUT_BYTES-1:0]  acc_kep_q, merged_kep;
  logic [FILL_W-1:0]     fill_q;
  logic [CNT_W-1:0]      pkt_cnt_q;
  logic                  err_q;
  logic [N_W-1:0]        keep_n, eff_n;
  logic                  keep_contig;
  logic [IN_BYTES*8-1:0] word_dat;
  logic [IN_BYTES-1:0]   word_kep;
  logic                  m_vld, s_rdy, accept, m_hs, complete, drop, emit, bad_keep;

  tx_keep_count #(.W(IN_BYTES)) u_keep_count (
    .keep   (i_s_tkeep),
    .n      (keep_n),
    .contig (keep_contig)
  );

  assign m_vld    = (state_q == HOLD);
  assign s_rdy    = !m_vld || i_m_tready;
  assign accept   = i_s_tvalid && s_rdy;
  assign m_hs     = m_vld && i_m_tready;
  assign complete = i_s_tlast || (fill_q == FILL_W'(OUT_BYTES - IN_BYTES));
  // An empty last word on an empty accumulator closes nothing, so no beat is produced.
  assign drop     = i_s_tlast && (keep_n == '0) && (fill_q == '0);
  assign emit     = accept && complete && !drop;
  assign bad_keep = i_s_tlast ? !keep_contig : (keep_n != N_W'(IN_BYTES));
  // Mid-packet words always occupy a full slot so later words stay lane-aligned.
  assign eff_n    = i_s_tlast ? keep_n : N_W'(IN_BYTES);

  always_comb begin
    word_dat = '0;
    word_kep = '0;
    for (int b = 0; b < IN_BYTES; b++) begin
      if (b < int'(eff_n)) begin
        word_dat[b*8 +: 8] = i_s_tdata[b*8 +: 8];
        word_kep[b]        = 1'b1;
      end
    end
    merged_dat = acc_dat_q | (DAT_W'(word_dat) << {fill_q, 3'b000});
    merged_kep = acc_kep_q | (OUT_BYTES'(word_kep) << fill_q);
  end

  always_comb begin
    beat_d = '0;
    beat_d.a64x8_tdata[OUT_BYTES-1:0] = merged_dat;
    beat_d.v64_tkeep[OUT_BYTES-1:0]   = merged_kep;
    beat_d.tlast                      = i_s_tlast;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_FILL: if (emit) state_d = HOLD;
      HOLD:      if (m_hs && !emit) state_d = IDLE_FILL;
      default:   state_d = IDLE_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE_FILL;
      beat_q    <= '0;
      acc_dat_q <= '0;
      acc_kep_q <= '0;
      fill_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && bad_keep;
      if (emit) begin
        beat_q <= beat_d;
      end
      if (accept) begin
        if (complete) begin
          acc_dat_q <= '0;
          acc_kep_q <= '0;
          fill_q    <= '0;
        end else begin
          acc_dat_q <= merged_dat;
          acc_kep_q <= merged_kep;
          fill_q    <= fill_q + FILL_W'(IN_BYTES);
        end
      end
      if (m_hs && beat_q.tlast) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_s_tready = s_rdy;
  assign o_m_tvalid = m_vld;
  assign o_m_tdata  = beat_q.a64x8_tdata[OUT_BYTES-1:0];
  assign o_m_tkeep  = beat_q.v64_tkeep[OUT_BYTES-1:0];
  assign o_m_tlast  = beat_q.tlast;
  assign o_pkt_cnt  = pkt_cnt_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_tx_dma_axis_packer.sv
// Directed bench for tx_dma_axis_packer: packing, partial last words, stalls, illegal keep, async reset.
module tb_tx_dma_axis_packer;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [63:0]  i_s_tdata;
  logic [7:0]   i_s_tkeep;
  logic         i_s_tlast;
  logic         i_s_tvalid;
  logic         o_s_tready;
  logic [511:0] o_m_tdata;
  logic [63:0]  o_m_tkeep;
  logic         o_m_tlast;
  logic         o_m_tvalid;
  logic         i_m_tready;
  logic [15:0]  o_pkt_cnt;
  logic         o_err;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  tx_dma_axis_packer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_s_tdata  (i_s_tdata),
    .i_s_tkeep  (i_s_tkeep),
    .i_s_tlast  (i_s_tlast),
    .i_s_tvalid (i_s_tvalid),
    .o_s_tready (o_s_tready),
    .o_m_tdata  (o_m_tdata),
    .o_m_tkeep  (o_m_tkeep),
    .o_m_tlast  (o_m_tlast),
    .o_m_tvalid (o_m_tvalid),
    .i_m_tready (i_m_tready),
    .o_pkt_cnt  (o_pkt_cnt),
    .o_err      (o_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input logic [7:0] base);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = base + 8'(b);
    return w;
  endfunction

  // Beat whose byte i holds base+i for i < nbytes and zero above.
  function automatic logic [511:0] seq_beat(input logic [7:0] base, input int nbytes);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < nbytes; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    i_s_tdata  = d;
    i_s_tkeep  = k;
    i_s_tlast  = l;
    i_s_tvalid = 1'b1;
    @(posedge i_clk);
    #1;
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_s_tdata  = '0;
    i_s_tkeep  = '0;
    i_s_tlast  = 1'b0;
    i_s_tvalid = 1'b0;
    i_m_tready = 1'b1;
    #2;
    chk("rst_tvalid", 512'(o_m_tvalid), 512'(0));
    chk("rst_tdata", o_m_tdata, '0);
    chk("rst_tkeep", 512'(o_m_tkeep), 512'(0));
    chk("rst_tlast", 512'(o_m_tlast), 512'(0));
    chk("rst_pkt_cnt", 512'(o_pkt_cnt), 512'(0));
    chk("rst_err", 512'(o_err), 512'(0));
    chk("rst_s_tready", 512'(o_s_tready), 512'(1));
    #6 i_rst = 1'b0;
    tick();

    // Eight full words, last one closes the packet.
    for (int w = 0; w < 7; w++) send(mkword(8'(w * 8)), 8'hFF, 1'b0);
    chk("full_no_early_beat", 512'(o_m_tvalid), 512'(0));
    send(mkword(8'd56), 8'hFF, 1'b1);
    chk("full_tvalid", 512'(o_m_tvalid), 512'(1));
    chk("full_tdata", o_m_tdata, seq_beat(8'h00, 64));
    chk("full_tkeep", 512'(o_m_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("full_tlast", 512'(o_m_tlast), 512'(1));
    tick();
    chk("full_drained", 512'(o_m_tvalid), 512'(0));
    chk("full_pkt_cnt", 512'(o_pkt_cnt), 512'(1));

    // Short packet ending in a half word; the last word's unused lanes carry junk.
    send(mkword(8'h40), 8'hFF, 1'b0);
    send(mkword(8'h48), 8'hFF, 1'b0);
    send(64'hEEEE_EEEE_5352_5150, 8'h0F, 1'b1);
    chk("short_tvalid", 512'(o_m_tvalid), 512'(1));
    chk("short_tkeep", 512'(o_m_tkeep), 512'(64'h0000_0000_000F_FFFF));
    chk("short_tdata", o_m_tdata, seq_beat(8'h40, 20));
    chk("short_tlast", 512'(o_m_tlast), 512'(1));
    tick();
    chk("short_pkt_cnt", 512'(o_pkt_cnt), 512'(2));

    // Stall a full mid-packet beat, then release with a completing word waiting.
    i_m_tready = 1'b0;
    for (int w = 0; w < 8; w++) send(mkword(8'(8'h80 + w * 8)), 8'hFF, 1'b0);
    i_s_tdata  = mkword(8'hC0);
    i_s_tkeep  = 8'hFF;
    i_s_tlast  = 1'b1;
    i_s_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_s_tready", 512'(o_s_tready), 512'(0));
      chk("stall_tvalid", 512'(o_m_tvalid), 512'(1));
      chk("stall_tdata", o_m_tdata, seq_beat(8'h80, 64));
      chk("stall_tlast", 512'(o_m_tlast), 512'(0));
      tick();
    end
    i_m_tready = 1'b1;
    tick();
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
    chk("b2b_tvalid", 512'(o_m_tvalid), 512'(1));
    chk("b2b_tdata", o_m_tdata, seq_beat(8'hC0, 8));
    chk("b2b_tkeep", 512'(o_m_tkeep), 512'(64'hFF));
    chk("b2b_tlast", 512'(o_m_tlast), 512'(1));
    chk("b2b_pkt_cnt_mid", 512'(o_pkt_cnt), 512'(2));
    tick();
    chk("b2b_pkt_cnt", 512'(o_pkt_cnt), 512'(3));
    chk("b2b_drained", 512'(o_m_tvalid), 512'(0));

    // Partial keep on a non-last word: flagged, but lanes still fully packed.
    send(mkword(8'h00), 8'h3F, 1'b0);
    chk("badkeep_err", 512'(o_err), 512'(1));
    send(mkword(8'h08), 8'hFF, 1'b0);
    chk("badkeep_err_once", 512'(o_err), 512'(0));
    for (int w = 2; w < 8; w++) send(mkword(8'(w * 8)), 8'hFF, 1'b0);
    chk("badkeep_tvalid", 512'(o_m_tvalid), 512'(1));
    chk("badkeep_tkeep", 512'(o_m_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("badkeep_tdata", o_m_tdata, seq_beat(8'h00, 64));
    chk("badkeep_tlast", 512'(o_m_tlast), 512'(0));
    tick();
    chk("badkeep_pkt_cnt", 512'(o_pkt_cnt), 512'(3));

    // Empty last word: swallowed at fill 0, closes the beat at fill 16.
    send(mkword(8'h11), 8'h00, 1'b1);
    chk("empty0_tvalid", 512'(o_m_tvalid), 512'(0));
    chk("empty0_err", 512'(o_err), 512'(0));
    tick();
    chk("empty0_tvalid_later", 512'(o_m_tvalid), 512'(0));
    chk("empty0_pkt_cnt", 512'(o_pkt_cnt), 512'(3));
    send(mkword(8'h20), 8'hFF, 1'b0);
    send(mkword(8'h28), 8'hFF, 1'b0);
    send(mkword(8'h99), 8'h00, 1'b1);
    chk("empty16_tvalid", 512'(o_m_tvalid), 512'(1));
    chk("empty16_tkeep", 512'(o_m_tkeep), 512'(64'hFFFF));
    chk("empty16_tdata", o_m_tdata, seq_beat(8'h20, 16));
    chk("empty16_tlast", 512'(o_m_tlast), 512'(1));
    chk("empty16_err", 512'(o_err), 512'(0));
    tick();
    chk("empty16_pkt_cnt", 512'(o_pkt_cnt), 512'(4));

    // Async reset while a beat is held.
    i_m_tready = 1'b0;
    for (int w = 0; w < 8; w++) send(mkword(8'(8'h30 + w * 8)), 8'hFF, 1'b0);
    chk("hold_before_rst", 512'(o_m_tvalid), 512'(1));
    #3 i_rst = 1'b1;
    #1;
    chk("rstA_tvalid", 512'(o_m_tvalid), 512'(0));
    chk("rstA_tdata", o_m_tdata, '0);
    chk("rstA_tkeep", 512'(o_m_tkeep), 512'(0));
    chk("rstA_pkt_cnt", 512'(o_pkt_cnt), 512'(0));
    chk("rstA_s_tready", 512'(o_s_tready), 512'(1));
    #2 i_rst = 1'b0;
    i_m_tready = 1'b1;
    tick();

    // Async reset with 24 bytes accumulated, then a clean packet from byte 0.
    for (int w = 0; w < 3; w++) send(mkword(8'hA0), 8'hFF, 1'b0);
    #3 i_rst = 1'b1;
    #1;
    chk("rstB_tvalid", 512'(o_m_tvalid), 512'(0));
    #2 i_rst = 1'b0;
    tick();
    chk("rstB_quiet", 512'(o_m_tvalid), 512'(0));
    for (int w = 0; w < 7; w++) send(mkword(8'(w * 8)), 8'hFF, 1'b0);
    chk("rstB_no_early_beat", 512'(o_m_tvalid), 512'(0));
    send(mkword(8'd56), 8'hFF, 1'b1);
    chk("rstB_tvalid_beat", 512'(o_m_tvalid), 512'(1));
    chk("rstB_tdata", o_m_tdata, seq_beat(8'h00, 64));
    chk("rstB_tkeep", 512'(o_m_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    tick();
    chk("rstB_pkt_cnt", 512'(o_pkt_cnt), 512'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
